scan_chain_controller: RTL
==========================

Name: scan_chain_controller

Overview:
- Sequencer that drives the scan-chain inputs of the daisy-chained scan wrappers: scan clock, scan data, scan select and latch enable.
- One transaction does three things:
  - shifts a parallel input vector into the chain and latches it onto the designs' inputs;
  - captures the designs' outputs into the chain;
  - shifts the chain back out into a parallel result register.
- Replaces bit-banging the chain from the logic analyser; the CPU-side logic only issues start and reads the result.

Parameters:
- NUM_DESIGNS, 4, number of scan wrappers in the chain.
- NUM_IOS, 8, scan flops per wrapper.
- SCAN_HALF_PERIOD, 1, wb_clk_i cycles per scan_clk_o phase; legal values are 1 or greater.
- Derived: TOTAL = NUM_DESIGNS*NUM_IOS, 32 by default.

Ports:
- wb_clk_i  input  1  system clock; all logic is on the rising edge.
- wb_rst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  begin a transaction; sampled only in IDLE.
- inputs_i  input  TOTAL  vector to load into the chain; captured when start is accepted.
- busy_o  output  1  high while a transaction runs.
- done_o  output  1  one-cycle pulse when result_o updates.
- result_o  output  TOTAL  captured chain contents, in the same bit ordering as inputs_i.
- scan_clk_o  output  1  chain clock.
- scan_data_o  output  1  serial data into the chain.
- scan_select_o  output  1  1 = chain parallel-captures design outputs on the scan_clk rise; 0 = shift.
- scan_latch_en_o  output  1  latches chain contents onto design inputs.
- scan_data_i  input  1  serial data from the chain tail.

Behaviour:
- Reset: async assert clears the FSM to IDLE. All outputs, including result_o, go to 0 immediately, whatever the state (including mid-transaction).
- Let H = SCAN_HALF_PERIOD. A scan bit period is 2H cycles: scan_clk_o is low for H cycles, then high for H cycles.
- scan_data_o and scan_select_o change only at the start of the low phase.
- IDLE:
  - All scan outputs are 0.
  - start_i=1 loads sreg<=inputs_i and bitcnt<=TOTAL, then moves to SHIFT_IN on the next edge.
  - busy_o goes high in the cycle after acceptance.
- SHIFT_IN:
  - scan_data_o = sreg[TOTAL-1], i.e. MSB first.
  - At the end of each bit period: sreg shifts left, bitcnt decrements.
  - After TOTAL bits, go to LATCH. Bit 0 of inputs_i ends in the chain head flop.
- LATCH: scan_latch_en_o is high for H cycles, then low for H cycles. Then go to CAPTURE.
- CAPTURE: scan_select_o=1 for one full bit period, giving one scan_clk rise. Then go to SHIFT_OUT with scan_select_o=0.
- SHIFT_OUT:
  - scan_data_o = 0; TOTAL bit periods.
  - scan_data_i is sampled in the last low-phase cycle before each rise and shifted into cap[0] with a left shift.
  - After TOTAL samples, cap holds the chain contents in inputs_i ordering. Go to DONE.
- DONE:
  - result_o <= cap, done_o=1 for exactly this cycle, busy_o still 1.
  - Next state is IDLE. result_o holds until the next DONE or reset.
- Latency: busy_o is high for 2H*TOTAL + 4H + 2H*TOTAL + 1 cycles. That is 133 cycles for the defaults.
- Per transaction:
  - scan_clk_o rises exactly 2*TOTAL+1 times;
  - scan_latch_en_o gives exactly one pulse of H cycles;
  - scan_select_o is high for exactly 2H cycles.
- start_i while busy is ignored; no queuing.
- start_i held high gives back-to-back transactions with exactly one IDLE cycle between them.
- Counters must not wrap; bitcnt is sized for TOTAL.

Test Plan:
- Reset behaviour: assert wb_rst_n_i=0 with no clock running -> all outputs 0 immediately. Release reset -> IDLE, busy_o=0.
- Identity transaction:
  - Setup: behavioural chain model with 4x8 flops; each design's outputs equal its latched inputs.
  - Stimulus: inputs_i=32'hA5C30F01, start for 1 cycle.
  - Required: busy_o high for 133 cycles, one done_o pulse, result_o=32'hA5C30F01.
  - Required: 65 scan_clk rises, 1 latch pulse, scan_select high for 2 cycles.
- Inverting transaction: designs output ~inputs; inputs_i=32'h0000FFFF -> result_o=32'hFFFF0000.
- Slow scan clock: SCAN_HALF_PERIOD=3, inputs_i=32'h12345678, identity designs -> busy_o high for 397 cycles, result_o=32'h12345678, each scan_clk phase lasts 3 cycles.
- Start handling:
  - Pulse start_i mid-transaction -> no effect on timing or result.
  - Hold start_i high -> second busy period begins exactly 1 cycle after done_o.
- Mid-transaction reset:
  - Assert reset during SHIFT_OUT, after a prior result of 32'hA5C30F01 -> result_o=0 and all scan outputs 0 immediately.
  - Then a new start with 32'h00000001 -> result_o=32'h00000001.

Source files
------------

// File: rtl/scan_chain_controller.sv
// Scan-chain sequencer: shifts a parallel vector into the daisy-chained scan wrappers,
// latches it, captures the design outputs and shifts them back into a result register.
module scan_chain_controller #(
    parameter int NUM_DESIGNS      = 4,
    parameter int NUM_IOS          = 8,
    parameter int SCAN_HALF_PERIOD = 1
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_n_i,
    input  logic                             start_i,
    input  logic [NUM_DESIGNS*NUM_IOS-1:0]   inputs_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [NUM_DESIGNS*NUM_IOS-1:0]   result_o,
    output logic                             scan_clk_o,
    output logic                             scan_data_o,
    output logic                             scan_select_o,
    output logic                             scan_latch_en_o,
    input  logic                             scan_data_i
);

    localparam int TOTAL = NUM_DESIGNS * NUM_IOS;
    localparam int H     = SCAN_HALF_PERIOD;
    localparam int PW    = $clog2(2 * H);
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [PW-1:0] PH_LOW_LAST = PW'(H - 1);
    localparam logic [PW-1:0] PH_HIGH     = PW'(H);
    localparam logic [PW-1:0] PH_LAST     = PW'(2 * H - 1);
    localparam logic [CW-1:0] CNT_TOTAL   = CW'(TOTAL);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_LATCH,
        S_CAPTURE,
        S_SHIFT_OUT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ph_q, ph_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [TOTAL-1:0] sreg_q, sreg_d;
    logic [TOTAL-1:0] cap_q, cap_d;
    logic [TOTAL-1:0] result_q, result_d;

    logic period_end;
    logic ph_high;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= S_IDLE;
            ph_q     <= '0;
            bitcnt_q <= '0;
            sreg_q   <= '0;
            cap_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            bitcnt_q <= bitcnt_d;
            sreg_q   <= sreg_d;
            cap_q    <= cap_d;
            result_q <= result_d;
        end
    end

    // ph_q runs 0..2H-1 across one scan bit period; the first H cycles are the low phase.
    assign period_end = (ph_q == PH_LAST);
    assign ph_high    = (ph_q >= PH_HIGH);

    always_comb begin
        state_d  = state_q;
        ph_d     = period_end ? '0 : ph_q + PW'(1);
        bitcnt_d = bitcnt_q;
        sreg_d   = sreg_q;
        cap_d    = cap_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                ph_d = '0;
                if (start_i) begin
                    sreg_d   = inputs_i;
                    bitcnt_d = CNT_TOTAL;
                    state_d  = S_SHIFT_IN;
                end
            end
            S_SHIFT_IN: begin
                if (period_end) begin
                    sreg_d   = sreg_q << 1;
                    bitcnt_d = bitcnt_q - CNT_ONE;
                    if (bitcnt_q == CNT_ONE) state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (period_end) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (period_end) begin
                    bitcnt_d = CNT_TOTAL;
                    state_d  = S_SHIFT_OUT;
                end
            end
            S_SHIFT_OUT: begin
                // Sample the chain tail just before the rise that advances it.
                if (ph_q == PH_LOW_LAST) cap_d = {cap_q[TOTAL-2:0], scan_data_i};
                if (period_end) begin
                    bitcnt_d = bitcnt_q - CNT_ONE;
                    if (bitcnt_q == CNT_ONE) begin
                        result_d = cap_q;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ph_d    = '0;
                state_d = S_IDLE;
            end
            default: begin
                ph_d    = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = (state_q == S_DONE);
    assign result_o        = result_q;
    assign scan_clk_o      = ph_high && ((state_q == S_SHIFT_IN) || (state_q == S_CAPTURE) ||
                                         (state_q == S_SHIFT_OUT));
    assign scan_data_o     = (state_q == S_SHIFT_IN) && sreg_q[TOTAL-1];
    assign scan_select_o   = (state_q == S_CAPTURE);
    assign scan_latch_en_o = (state_q == S_LATCH) && !ph_high;

endmodule
